// File: rtl/wave_led_pkg.sv
// Shared types and sequence-length helper for the LED sequence engine.
package wave_led_pkg;

    typedef enum logic [1:0] {
        MODE_WAVE   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of steps in one pass of the given pattern on an n-wide bank.
    function automatic int unsigned seq_len(input mode_t mode, input int unsigned n);
        int unsigned len;
        case (mode)
            MODE_WAVE:   len = n;
            MODE_BOUNCE: len = (32'd2 * n) - 32'd2;
            MODE_FILL:   len = n;
            MODE_BLINK:  len = 32'd2 * n;
            default:     len = n;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/wave_led_seq_tick_prescaler.sv
// tick_prescaler: free-running 0..DIV-1 counter with synchronous clear;
// tick is high during the last count of each period.
module tick_prescaler #(
    parameter int DIV = 4,
    parameter int W   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_end_s;

    assign at_end_s = (cnt_q == W'(DIV - 1));
    assign tick     = at_end_s & ~clr;

    // Next count: hold at zero while cleared, wrap at the end of the period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (at_end_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wave_led_seq.sv
// wave_led_seq: N-wide LED pattern engine (wave/bounce/fill/blink) with start/stop,
// one-shot or repeat. Define WAVE_LED_ACTIVE_LOW_EN for active-low LED pins.
module wave_led_seq
    import wave_led_pkg::*;
#(
    parameter int N_LEDS   = 6,
    parameter int STEP_DIV = 1_350_000,
    parameter int DIV_W    = $clog2(STEP_DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              repeat_en,
    output logic [N_LEDS-1:0] LED,
    output logic              busy,
    output logic              done
);

    localparam int SW = $clog2(2 * N_LEDS);
    localparam logic [N_LEDS-1:0] ONE_HOT0 = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] ALL_ON   = {N_LEDS{1'b1}};
`ifdef WAVE_LED_ACTIVE_LOW_EN
    localparam logic [N_LEDS-1:0] LED_OFF  = {N_LEDS{1'b1}};
`else
    localparam logic [N_LEDS-1:0] LED_OFF  = {N_LEDS{1'b0}};
`endif

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [SW-1:0]     step_q, step_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_s;
    logic              clr_s;
    logic [SW-1:0]     last_step_s;
    logic [SW-1:0]     pos_s;
    logic [N_LEDS-1:0] pat_s;

    // Prescaler only runs while a sequence is live; stop clears it immediately.
    assign clr_s       = (state_q != ST_RUN) | stop;
    assign last_step_s = SW'(seq_len(mode_q, N_LEDS) - 32'd1);

    tick_prescaler #(
        .DIV (STEP_DIV),
        .W   (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // FSM next state, step counter and done pulse.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    mode_d  = mode_t'(mode);
                    step_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (tick_s) begin
                    if (step_q == last_step_s) begin
                        done_d  = 1'b1;
                        step_d  = '0;
                        state_d = repeat_en ? ST_RUN : ST_IDLE;
                    end else begin
                        step_d  = step_q + SW'(1);
                    end
                end else begin
                    step_d = step_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Pattern for the upcoming step, decoded so the output can be registered.
    always_comb begin
        pat_s = '0;
        pos_s = '0;
        case (mode_d)
            MODE_WAVE:   pat_s = ONE_HOT0 << step_d;
            MODE_BOUNCE: begin
                if (step_d < SW'(N_LEDS)) begin
                    pos_s = step_d;
                end else begin
                    pos_s = SW'(2 * N_LEDS - 2) - step_d;
                end
                pat_s = ONE_HOT0 << pos_s;
            end
            MODE_FILL:   pat_s = ~(ALL_ON << (step_d + SW'(1)));
            MODE_BLINK:  pat_s = step_d[0] ? {N_LEDS{1'b0}} : ALL_ON;
            default:     pat_s = '0;
        endcase
    end

    // Output values; polarity is applied only here.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        if (state_d == ST_RUN) begin
`ifdef WAVE_LED_ACTIVE_LOW_EN
            led_d = ~pat_s;
`else
            led_d = pat_s;
`endif
        end else begin
            led_d = LED_OFF;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WAVE;
            step_q  <= '0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign LED  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_wave_led_seq.sv
// Directed self-checking bench for wave_led_seq with N_LEDS=6, STEP_DIV=4.
module tb_wave_led_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       repeat_en;
    logic [5:0] LED;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int lit5   = 0;
    logic [5:0] exp_tab [12];

    wave_led_seq #(
        .N_LEDS   (6),
        .STEP_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .repeat_en (repeat_en),
        .LED       (LED),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] led_exp(input logic [5:0] p);
`ifdef WAVE_LED_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check n steps (from exp_tab[first]) each held for 4 cycles with busy high, done low.
    task automatic run_steps(input string tag, input int first, input int n);
        for (int s = first; s < first + n; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_led"}, 32'(LED), 32'(led_exp(exp_tab[s])));
                chk({tag, "_busy"}, 32'(busy), 32'd1);
                chk({tag, "_done"}, 32'(done), 32'd0);
                if (c == 0 && led_exp(LED)[5]) lit5++;
                tick();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; repeat_en = 1'b0;
        tick(); tick();
        chk("rst_led",  32'(LED),  32'(led_exp(6'h00)));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // WAVE one-shot
        exp_tab = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        mode = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        run_steps("wave", 0, 6);
        chk("wave_done_pulse", 32'(done), 32'd1);
        chk("wave_end_led",    32'(LED),  32'(led_exp(6'h00)));
        chk("wave_end_busy",   32'(busy), 32'd0);
        tick();
        chk("wave_done_clear", 32'(done), 32'd0);

        // BOUNCE one-shot: LED[5] lit in exactly one step
        exp_tab = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
                    6'h10, 6'h08, 6'h04, 6'h02, 6'h00, 6'h00};
        mode = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        lit5 = 0;
        run_steps("bounce", 0, 10);
        chk("bounce_led5_once",  32'(lit5), 32'd1);
        chk("bounce_done_pulse", 32'(done), 32'd1);
        chk("bounce_end_busy",   32'(busy), 32'd0);
        chk("bounce_end_led",    32'(LED),  32'(led_exp(6'h00)));

        // FILL with repeat, then repeat cleared for the second pass
        exp_tab = '{6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3f,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        mode = 2'd2; repeat_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        run_steps("fill1", 0, 6);
        chk("fill_rep_done", 32'(done), 32'd1);
        chk("fill_rep_led",  32'(LED),  32'(led_exp(6'h01)));
        chk("fill_rep_busy", 32'(busy), 32'd1);
        repeat_en = 1'b0;
        tick();
        for (int c = 1; c < 4; c++) begin
            chk("fill2_step0_led", 32'(LED), 32'(led_exp(6'h01)));
            chk("fill2_step0_done", 32'(done), 32'd0);
            tick();
        end
        run_steps("fill2", 1, 5);
        chk("fill2_done", 32'(done), 32'd1);
        chk("fill2_led",  32'(LED),  32'(led_exp(6'h00)));
        chk("fill2_busy", 32'(busy), 32'd0);

        // BLINK aborted by stop at step 3
        exp_tab = '{6'h3f, 6'h00, 6'h3f, 6'h00, 6'h3f, 6'h00,
                    6'h3f, 6'h00, 6'h3f, 6'h00, 6'h3f, 6'h00};
        mode = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        run_steps("blink", 0, 3);
        chk("blink_s3_led",  32'(LED),  32'(led_exp(6'h00)));
        chk("blink_s3_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_led",  32'(LED),  32'(led_exp(6'h00)));
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("stop_no_done", 32'(done), 32'd0);
            chk("stop_stay_idle", 32'(busy), 32'd0);
        end

        // start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);
        chk("startstop_led",  32'(LED),  32'(led_exp(6'h00)));
        tick();
        chk("startstop_busy2", 32'(busy), 32'd0);

        // Asynchronous reset during WAVE step 2
        exp_tab = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        mode = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        run_steps("wave_r", 0, 2);
        chk("wave_r_s2_led", 32'(LED), 32'(led_exp(6'h04)));
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led",  32'(LED),  32'(led_exp(6'h00)));
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // start held through a run; mode change applies only on restart
        mode = 2'd0; start = 1'b1;
        tick();
        run_steps("hold0", 0, 1);
        mode = 2'd2;
        run_steps("hold_wave", 1, 5);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_led",  32'(LED),  32'(led_exp(6'h00)));
        chk("hold_busy", 32'(busy), 32'd0);
        tick();
        exp_tab = '{6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3f,
                    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        run_steps("newmode_fill", 0, 2);
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wave_led_seq.md
# wave_led_seq

Parametrised LED sequence engine, successor to the fixed 6-LED wave block. Drives an N-wide LED bank through one of four selectable patterns (wave, bounce, fill, blink), one step per programmable prescaler tick. Start/stop control, one-shot or repeat operation, and busy/done status let a top-level controller or button debouncer sequence it. Sits between board I/O (buttons/UART command decoder) and the LED pins.

## Interface
- `N_LEDS`, 6: LED count, legal range 2..32
- `STEP_DIV`, 1_350_000: clk cycles per pattern step (≥2)
- `DIV_W`, `$clog2(STEP_DIV)`: prescaler counter width
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level sampled each cycle; acts in IDLE only
- `stop`  in  1  abort current sequence
- `mode`  in  2  pattern select, captured on accepted start
- `repeat_en`  in  1  restart automatically after last step, sampled at sequence end
- `LED`  out  N_LEDS  LED drive, registered
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse on natural sequence completion

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: LED all-off, prescaler and step counter cleared. `start`=1 → RUN, `mode` latched into `mode_q`, step=0.
- RUN: pattern for current step shown; prescaler counts 0..STEP_DIV-1; at STEP_DIV-1 step advances.
- Patterns (bit 0 = LED[0]), length L:
  - 0 WAVE: one-hot `1<<step`, L=N_LEDS
  - 1 BOUNCE: one-hot position 0,1..N-1,N-2..1, L=2·N_LEDS-2
  - 2 FILL: lowest step+1 bits set, L=N_LEDS
  - 3 BLINK: all-on on even steps, all-off on odd, L=2·N_LEDS
- After last step's dwell: `done` pulse. If `repeat_en`=1, step=0 and stay in RUN (no gap cycle); else → IDLE, LED off.
- `stop`=1 in RUN: → IDLE next edge, LED off, no `done`. `stop` and `start` same cycle in IDLE: stop wins, remain IDLE.
- `start` in RUN ignored; `mode` changes in RUN ignored until next start.
- Step counter width `$clog2(2·N_LEDS)`; never exceeds L-1.
- Reset asserted mid-sequence: immediate return to reset values.

## Timing
- Reset values: LED=0 (see Configuration), busy=0, done=0, state IDLE.
- Start latency: `start` high at edge k → busy=1 and first pattern on LED after edge k (visible cycle k+1).
- Each step held exactly STEP_DIV cycles; full sequence L·STEP_DIV cycles.
- `done` high for the single cycle following last step's dwell, coincident with LED going off (one-shot) or step-0 pattern (repeat).
- `stop` latency: one edge to LED off, busy=0.
- All outputs registered; no combinational input→output paths.

## Configuration
- `WAVE_LED_ACTIVE_LOW_EN` defined: LED output inverted (on=0), reset/idle value all-ones — for Gowin boards with active-low LEDs.
- Undefined: active-high, reset/idle value all-zeros. Internal pattern logic identical; inversion only at output register.

## Structure
- Package `wave_led_pkg`: `mode_t` enum (MODE_WAVE, MODE_BOUNCE, MODE_FILL, MODE_BLINK), `state_t` enum (ST_IDLE, ST_RUN), function `seq_len(mode, n)`.
- Sub-module `tick_prescaler` (params DIV, W; ports clk, rst_n, clr, tick): reusable for other display blocks.
- Top holds FSM, step counter, pattern decode, output register.

## Test plan
- N_LEDS=6, STEP_DIV=4, mode=0, start pulse → LED 000001,000010,…,100000 each 4 cycles, done pulse at cycle 25, then LED=0, busy=0.
- mode=1 → 10 steps, positions 0..5..1; LED[5] lit only once per sweep; done after 40 cycles.
- mode=2 with repeat_en=1 → 000001..111111 then 000001 immediately after done, busy stays 1; clear repeat_en → stops after next pass.
- mode=3 run, assert stop at step 3 → LED off next cycle, busy=0, no done; start+stop same cycle in IDLE → stays IDLE.
- rst_n low mid-WAVE step 2 → LED, busy, done at reset values asynchronously; with `WAVE_LED_ACTIVE_LOW_EN` LED=111111.
- start held high through sequence, mode changed mid-run → pattern unchanged until restart; new mode applied on restart.
